node_route_sequencer: RTL and testbench
=======================================

// Module: node_route_sequencer
// PURPOSE
//  Mission-level controller for the line-follow bot. Runs a programmable route table, one entry per node.
//  Detects nodes from the 3-bit line sensor; stops, picks or drops via the electromagnet, then commands the turn/straight manoeuvre.
//  Drives motion_cmd into the motor-speed datapath, which maps codes to the follow/turn/straight speed sets.
// PARAMETERS
//  N_NODES    8      route table depth; node_idx width = $clog2(N_NODES)
//  DEBOUNCE   4      consecutive 3'b111 samples needed to declare a node
//  MAG_HOLD   16     cycles the motors stay stopped while the magnet changes state
//  TURN_MIN   8      minimum MANEUVER cycles before the release condition is honoured
//  LOST_MAX   64     consecutive 3'b000 samples in FOLLOW before FAULT
// PORTS
//  clk            in   1   system clock (all logic on posedge)
//  rst            in   1   synchronous, active-high reset
//  start          in   1   single-cycle pulse; honoured only in IDLE, DONE or FAULT
//  adc_data       in   3   line sensors; MSB = left, LSB = right, 1 = line
//  route_wr_en    in   1   route table write strobe
//  route_wr_addr  in   IW  table index, IW = $clog2(N_NODES)
//  route_wr_data  in   3   [2] = toggle magnet at node; [1:0]: 00 go_st, 01 turn_R, 10 turn_L, 11 stop/end
//  motion_cmd     out  3   000 halt, 001 follow, 010 turn_R, 011 turn_L, 100 go_st
//  elctro         out  1   electromagnet drive (1 = holding)
//  node_idx       out  IW  index of the current/next route entry
//  busy           out  1   high in every state except IDLE, DONE and FAULT
//  done           out  1   high in DONE
//  fault          out  1   high in FAULT
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, every table entry = 3'b011, all counters 0.
//  All outputs are registered. The state register and outputs update on the same edge.
//  Table writes are accepted only in IDLE/DONE/FAULT and take effect the next cycle.
//  A write in the same cycle as an honoured start is dropped.
//  IDLE/DONE/FAULT --start--> FOLLOW. On start: node_idx <= 0, counters <= 0, elctro unchanged.
//  FOLLOW: motion_cmd=001.
//   - deb_cnt increments on adc==111 and clears otherwise.
//   - When deb_cnt reaches DEBOUNCE, go to NODE with motion_cmd=000.
//   - lost_cnt increments on adc==000 and clears otherwise. At LOST_MAX go to FAULT (motion_cmd=000).
//   - If both limits are hit in the same cycle, FAULT wins.
//  NODE (exactly 1 cycle, motion_cmd=000): latch entry[node_idx].
//   - bit2=1 -> MAG, and toggle elctro on this edge.
//   - else code 11 -> DONE.
//   - else -> MANEUVER.
//  MAG: motion_cmd=000 for MAG_HOLD cycles. Then code 11 -> DONE, else MANEUVER.
//  MANEUVER: motion_cmd set from the code (01->010, 10->011, 00->100). man_cnt counts from 0.
//   Exit only when man_cnt >= TURN_MIN-1 AND the release condition holds:
//   - turn_R: adc is 001 or 011.
//   - turn_L: adc is neither 111 nor 000.
//   - go_st:  adc == 010.
//   On exit:
//   - If node_idx == N_NODES-1 -> DONE (node_idx holds, no wrap).
//   - Else node_idx+1, go to FOLLOW, and clear deb_cnt/lost_cnt.
//  DONE/FAULT: motion_cmd=000 and elctro holds its value.
//  rst in any state (including mid-MAG or mid-MANEUVER) returns to the reset condition next edge.
//   This also releases the magnet and clears the table.
//  start while busy is ignored. adc values outside the listed codes (e.g. 101) count as neither node nor lost.
// TESTING
//  T1 rst 2 cycles -> all outputs 0; table read via a run with no writes gives NODE->DONE at idx 0.
//  T2 table {0:101, 1:001, 2:111}, start, then adc 010 -> 111x4 -> 011.
//     -> NODE, elctro=1 for MAG_HOLD, motion_cmd=010, release at man_cnt>=7, node_idx=1.
//  T3 adc=111 for only 3 cycles, then 010 -> no NODE; deb_cnt clears; motion_cmd stays 001.
//  T4 adc=000 for 64 cycles in FOLLOW -> fault=1, motion_cmd=000; a start pulse returns to FOLLOW at idx 0.
//  T5 entry 2=111 (drop+end) -> elctro toggles 1->0, MAG_HOLD halt, then done=1 with busy=0.
//  T6 rst asserted mid-MAG -> next cycle elctro=0, state IDLE; write in the same cycle as start is dropped.

Source files
------------

// File: rtl/node_route_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : node_route_sequencer_if
// Purpose  : Bundles the mission-level signals of the line-follow route
//            sequencer: start pulse, line sensor sample, route-table write
//            port, and the registered motion/magnet/status outputs.
// Ports    : master modport = controller side (drives start, adc_data and
//            route_wr_*; reads status). slave modport = sequencer side.
// Revision : 1.0 - initial release
// ============================================================================
interface node_route_sequencer_if #(
  parameter int N_NODES = 8
) ();
  localparam int IW = (N_NODES > 1) ? $clog2(N_NODES) : 1;

  logic          start;
  logic [2:0]    adc_data;
  logic          route_wr_en;
  logic [IW-1:0] route_wr_addr;
  logic [2:0]    route_wr_data;
  logic [2:0]    motion_cmd;
  logic          elctro;
  logic [IW-1:0] node_idx;
  logic          busy;
  logic          done;
  logic          fault;

  modport master (
    output start, adc_data, route_wr_en, route_wr_addr, route_wr_data,
    input  motion_cmd, elctro, node_idx, busy, done, fault
  );

  modport slave (
    input  start, adc_data, route_wr_en, route_wr_addr, route_wr_data,
    output motion_cmd, elctro, node_idx, busy, done, fault
  );
endinterface
`default_nettype wire

// File: rtl/node_route_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : node_route_sequencer
// Purpose  : Route-table driven mission controller for the line-follow bot.
//            Debounces node detection on the 3-bit line sensor, stops at the
//            node, optionally toggles the electromagnet (pick/drop), then
//            commands the turn/straight manoeuvre for that node.
// Ports    : clk  - system clock, all logic on posedge
//            rst  - synchronous active-high reset
//            bus  - node_route_sequencer_if.slave (start, adc_data,
//                   route_wr_*, motion_cmd, elctro, node_idx, busy, done,
//                   fault)
// Revision : 1.0 - initial release
// ============================================================================
module node_route_sequencer #(
  parameter int N_NODES  = 8,
  parameter int DEBOUNCE = 4,
  parameter int MAG_HOLD = 16,
  parameter int TURN_MIN = 8,
  parameter int LOST_MAX = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  node_route_sequencer_if.slave  bus
);

  localparam int IW = (N_NODES > 1) ? $clog2(N_NODES) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int LW = $clog2(LOST_MAX + 1);
  localparam int MW = (MAG_HOLD > 1) ? $clog2(MAG_HOLD) : 1;
  localparam int TW = (TURN_MIN > 1) ? $clog2(TURN_MIN) : 1;

  localparam logic [DW-1:0] DEB_LIM   = DW'(DEBOUNCE);
  localparam logic [LW-1:0] LOST_LIM  = LW'(LOST_MAX);
  localparam logic [MW-1:0] MAG_LAST  = MW'(MAG_HOLD - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_MIN - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_NODES - 1);

  localparam logic [2:0] CMD_HALT   = 3'b000;
  localparam logic [2:0] CMD_FOLLOW = 3'b001;
  localparam logic [2:0] CMD_TURN_R = 3'b010;
  localparam logic [2:0] CMD_TURN_L = 3'b011;
  localparam logic [2:0] CMD_GO_ST  = 3'b100;

  localparam logic [1:0] CODE_GO_ST  = 2'b00;
  localparam logic [1:0] CODE_TURN_R = 2'b01;
  localparam logic [1:0] CODE_TURN_L = 2'b10;
  localparam logic [1:0] CODE_END    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FOLLOW   = 3'd1,
    S_NODE     = 3'd2,
    S_MAG      = 3'd3,
    S_MANEUVER = 3'd4,
    S_DONE     = 3'd5,
    S_FAULT    = 3'd6
  } state_t;

  state_t        state;
  logic [2:0]    route_tbl [N_NODES];
  logic [1:0]    code;       // manoeuvre code latched at the node
  logic [DW-1:0] deb_cnt;
  logic [LW-1:0] lost_cnt;
  logic [MW-1:0] mag_cnt;
  logic [TW-1:0] man_cnt;    // saturates at TURN_MIN-1, which is all ">=" needs
  logic [2:0]    cmd;
  logic          mag_on;
  logic [IW-1:0] idx;
  logic          is_busy;
  logic          is_done;
  logic          is_fault;

  logic          quiescent;
  logic [DW-1:0] deb_next;
  logic [LW-1:0] lost_next;
  logic          release_ok;

  function automatic logic [2:0] code_to_cmd(input logic [1:0] c);
    case (c)
      CODE_TURN_R: code_to_cmd = CMD_TURN_R;
      CODE_TURN_L: code_to_cmd = CMD_TURN_L;
      CODE_GO_ST:  code_to_cmd = CMD_GO_ST;
      default:     code_to_cmd = CMD_HALT;
    endcase
  endfunction

  assign quiescent = (state == S_IDLE) || (state == S_DONE) || (state == S_FAULT);
  assign deb_next  = (bus.adc_data == 3'b111) ? deb_cnt + DW'(1) : '0;
  assign lost_next = (bus.adc_data == 3'b000) ? lost_cnt + LW'(1) : '0;

  // Manoeuvre is complete once the sensor pattern shows the bot has
  // re-acquired the line in the expected orientation.
  always_comb begin
    release_ok = 1'b0;
    case (code)
      CODE_TURN_R: release_ok = (bus.adc_data == 3'b001) || (bus.adc_data == 3'b011);
      CODE_TURN_L: release_ok = (bus.adc_data != 3'b111) && (bus.adc_data != 3'b000);
      CODE_GO_ST:  release_ok = (bus.adc_data == 3'b010);
      default:     release_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      for (int i = 0; i < N_NODES; i++) route_tbl[i] <= 3'b011;
      code     <= CODE_END;
      deb_cnt  <= '0;
      lost_cnt <= '0;
      mag_cnt  <= '0;
      man_cnt  <= '0;
      cmd      <= CMD_HALT;
      mag_on   <= 1'b0;
      idx      <= '0;
      is_busy  <= 1'b0;
      is_done  <= 1'b0;
      is_fault <= 1'b0;
    end else begin
      // A write racing an honoured start is dropped so the run sees a
      // stable table from its first cycle.
      if (quiescent && bus.route_wr_en && !bus.start)
        route_tbl[bus.route_wr_addr] <= bus.route_wr_data;

      case (state)
        S_IDLE, S_DONE, S_FAULT: begin
          if (bus.start) begin
            state    <= S_FOLLOW;
            cmd      <= CMD_FOLLOW;
            idx      <= '0;
            deb_cnt  <= '0;
            lost_cnt <= '0;
            mag_cnt  <= '0;
            man_cnt  <= '0;
            is_busy  <= 1'b1;
            is_done  <= 1'b0;
            is_fault <= 1'b0;
          end
        end

        S_FOLLOW: begin
          deb_cnt  <= deb_next;
          lost_cnt <= lost_next;
          if (lost_next == LOST_LIM) begin
            state    <= S_FAULT;
            cmd      <= CMD_HALT;
            is_busy  <= 1'b0;
            is_fault <= 1'b1;
          end else if (deb_next == DEB_LIM) begin
            state <= S_NODE;
            cmd   <= CMD_HALT;
          end
        end

        S_NODE: begin
          code <= route_tbl[idx][1:0];
          if (route_tbl[idx][2]) begin
            state   <= S_MAG;
            mag_on  <= ~mag_on;
            mag_cnt <= '0;
          end else if (route_tbl[idx][1:0] == CODE_END) begin
            state   <= S_DONE;
            is_busy <= 1'b0;
            is_done <= 1'b1;
          end else begin
            state   <= S_MANEUVER;
            cmd     <= code_to_cmd(route_tbl[idx][1:0]);
            man_cnt <= '0;
          end
        end

        S_MAG: begin
          if (mag_cnt == MAG_LAST) begin
            if (code == CODE_END) begin
              state   <= S_DONE;
              is_busy <= 1'b0;
              is_done <= 1'b1;
            end else begin
              state   <= S_MANEUVER;
              cmd     <= code_to_cmd(code);
              man_cnt <= '0;
            end
          end else begin
            mag_cnt <= mag_cnt + MW'(1);
          end
        end

        S_MANEUVER: begin
          if ((man_cnt == TURN_LAST) && release_ok) begin
            if (idx == LAST_IDX) begin
              state   <= S_DONE;
              cmd     <= CMD_HALT;
              is_busy <= 1'b0;
              is_done <= 1'b1;
            end else begin
              state    <= S_FOLLOW;
              cmd      <= CMD_FOLLOW;
              idx      <= idx + IW'(1);
              deb_cnt  <= '0;
              lost_cnt <= '0;
            end
          end else if (man_cnt != TURN_LAST) begin
            man_cnt <= man_cnt + TW'(1);
          end
        end

        default: begin
          state   <= S_IDLE;
          cmd     <= CMD_HALT;
          is_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.motion_cmd = cmd;
  assign bus.elctro     = mag_on;
  assign bus.node_idx   = idx;
  assign bus.busy       = is_busy;
  assign bus.done       = is_done;
  assign bus.fault      = is_fault;

endmodule
`default_nettype wire

// File: tb/tb_node_route_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_node_route_sequencer
// Purpose  : Self-checking bench for node_route_sequencer. Each scenario
//            builds a cycle-by-cycle plan of stimulus plus the output vector
//            expected after that edge; the expected vector is queued when
//            the stimulus is applied and popped when the outputs are sampled.
//            Vector layout: {motion_cmd[2:0], elctro, node_idx[2:0], busy,
//            done, fault}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_node_route_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;

  node_route_sequencer_if #(.N_NODES(8)) bus ();

  node_route_sequencer #(
    .N_NODES (8),
    .DEBOUNCE(4),
    .MAG_HOLD(16),
    .TURN_MIN(8),
    .LOST_MAX(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       st;
    logic       r;
    logic       we;
    logic [2:0] wa;
    logic [2:0] wd;
    logic [2:0] a;
    logic [9:0] e;
  } step_t;

  step_t      plan [$];
  logic [9:0] exp_q [$];
  int         checks = 0;
  int         fails  = 0;

  function automatic logic [9:0] v(input logic [2:0] c, input logic el,
                                   input logic [2:0] i, input logic b,
                                   input logic d, input logic f);
    return {c, el, i, b, d, f};
  endfunction

  function automatic logic [9:0] fol(input logic [2:0] i, input logic el);
    return v(3'b001, el, i, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic logic [9:0] hb(input logic [2:0] i, input logic el);
    return v(3'b000, el, i, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic logic [9:0] man(input logic [2:0] c, input logic [2:0] i, input logic el);
    return v(c, el, i, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic logic [9:0] dn(input logic [2:0] i, input logic el);
    return v(3'b000, el, i, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic logic [9:0] flt(input logic [2:0] i, input logic el);
    return v(3'b000, el, i, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic logic [9:0] observed();
    return {bus.motion_cmd, bus.elctro, bus.node_idx, bus.busy, bus.done, bus.fault};
  endfunction

  function automatic void add(input logic st, input logic r, input logic we,
                              input logic [2:0] wa, input logic [2:0] wd,
                              input logic [2:0] a, input logic [9:0] e);
    step_t s;
    s = '{st: st, r: r, we: we, wa: wa, wd: wd, a: a, e: e};
    plan.push_back(s);
  endfunction

  function automatic void sim(input logic [2:0] a, input logic [9:0] e);
    add(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, a, e);
  endfunction
  function automatic void rep(input int n, input logic [2:0] a, input logic [9:0] e);
    for (int k = 0; k < n; k++) add(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, a, e);
  endfunction
  function automatic void stp(input logic [2:0] a, input logic [9:0] e);
    add(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, a, e);
  endfunction
  function automatic void wr(input logic [2:0] wa, input logic [2:0] wd, input logic [9:0] e);
    add(1'b0, 1'b0, 1'b1, wa, wd, 3'b010, e);
  endfunction
  function automatic void rs();
    add(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'b010, 10'd0);
  endfunction

  // Apply one cycle of stimulus, queue the vector expected after the edge,
  // and leave the outputs ready to sample 1 time unit past that edge.
  task automatic drive(input step_t s);
    bus.start         = s.st;
    rst               = s.r;
    bus.route_wr_en   = s.we;
    bus.route_wr_addr = s.wa;
    bus.route_wr_data = s.wd;
    bus.adc_data      = s.a;
    exp_q.push_back(s.e);
    @(posedge clk);
    #1;
    bus.start       = 1'b0;
    rst             = 1'b0;
    bus.route_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] e;
    plan.delete();
    rs(); rs();
    stp(3'b010, fol(0, 0));
    rep(3, 3'b111, fol(0, 0));
    sim(3'b111, hb(0, 0));
    sim(3'b010, dn(0, 0));            // default entry 011 -> straight to DONE
    for (int k = 0; k < plan.size(); k++) begin
      drive(plan[k]);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL test_reset step %0d: got %b required %b", k, observed(), e);
      end
    end
  endtask

  task automatic test_pick_turn();
    logic [9:0] e;
    plan.delete();
    wr(3'd0, 3'b101, dn(0, 0));
    wr(3'd1, 3'b001, dn(0, 0));
    wr(3'd2, 3'b111, dn(0, 0));
    stp(3'b010, fol(0, 0));
    sim(3'b010, fol(0, 0));
    rep(3, 3'b111, fol(0, 0));
    sim(3'b111, hb(0, 0));            // NODE
    sim(3'b011, hb(0, 1));            // MAG entered, magnet on
    rep(15, 3'b011, hb(0, 1));
    sim(3'b011, man(3'b010, 0, 1));   // MAG_HOLD elapsed -> turn_R
    rep(7, 3'b011, man(3'b010, 0, 1));
    sim(3'b011, fol(1, 1));           // released at man_cnt == 7
    for (int k = 0; k < plan.size(); k++) begin
      drive(plan[k]);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL test_pick_turn step %0d: got %b required %b", k, observed(), e);
      end
    end
  endtask

  task automatic test_release();
    logic [9:0] e;
    plan.delete();
    rep(3, 3'b111, fol(1, 1));
    sim(3'b111, hb(1, 1));
    sim(3'b010, man(3'b010, 1, 1));   // entry 001: turn_R, no magnet change
    rep(10, 3'b010, man(3'b010, 1, 1));
    rep(2, 3'b101, man(3'b010, 1, 1));
    rep(2, 3'b111, man(3'b010, 1, 1));
    sim(3'b001, fol(2, 1));
    for (int k = 0; k < plan.size(); k++) begin
      drive(plan[k]);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL test_release step %0d: got %b required %b", k, observed(), e);
      end
    end
  endtask

  task automatic test_drop_end();
    logic [9:0] e;
    plan.delete();
    rep(3, 3'b111, fol(2, 1));
    sim(3'b111, hb(2, 1));
    sim(3'b010, hb(2, 0));            // entry 111: drop
    rep(15, 3'b010, hb(2, 0));
    sim(3'b010, dn(2, 0));
    sim(3'b010, dn(2, 0));
    for (int k = 0; k < plan.size(); k++) begin
      drive(plan[k]);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL test_drop_end step %0d: got %b required %b", k, observed(), e);
      end
    end
  endtask

  task automatic test_debounce();
    logic [9:0] e;
    plan.delete();
    rs();
    stp(3'b010, fol(0, 0));
    rep(3, 3'b111, fol(0, 0));
    sim(3'b010, fol(0, 0));
    rep(3, 3'b111, fol(0, 0));
    sim(3'b101, fol(0, 0));
    rep(3, 3'b111, fol(0, 0));
    sim(3'b010, fol(0, 0));
    rep(2, 3'b111, fol(0, 0));
    add(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'b111, fol(0, 0)); // start while busy
    sim(3'b111, hb(0, 0));
    sim(3'b010, dn(0, 0));
    for (int k = 0; k < plan.size(); k++) begin
      drive(plan[k]);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL test_debounce step %0d: got %b required %b", k, observed(), e);
      end
    end
  endtask

  task automatic test_lost();
    logic [9:0] e;
    plan.delete();
    stp(3'b010, fol(0, 0));
    rep(63, 3'b000, fol(0, 0));
    sim(3'b101, fol(0, 0));
    rep(63, 3'b000, fol(0, 0));
    sim(3'b000, flt(0, 0));
    sim(3'b000, flt(0, 0));
    stp(3'b010, fol(0, 0));
    sim(3'b010, fol(0, 0));
    for (int k = 0; k < plan.size(); k++) begin
      drive(plan[k]);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL test_lost step %0d: got %b required %b", k, observed(), e);
      end
    end
  endtask

  task automatic test_turn_left_straight();
    logic [9:0] e;
    plan.delete();
    rs();
    wr(3'd0, 3'b010, 10'd0);
    wr(3'd1, 3'b000, 10'd0);
    stp(3'b010, fol(0, 0));
    rep(3, 3'b111, fol(0, 0));
    sim(3'b111, hb(0, 0));
    sim(3'b000, man(3'b011, 0, 0));
    rep(9, 3'b000, man(3'b011, 0, 0));
    sim(3'b111, man(3'b011, 0, 0));
    sim(3'b110, fol(1, 0));
    rep(3, 3'b111, fol(1, 0));
    sim(3'b111, hb(1, 0));
    sim(3'b011, man(3'b100, 1, 0));
    rep(9, 3'b011, man(3'b100, 1, 0));
    sim(3'b010, fol(2, 0));
    rep(3, 3'b111, fol(2, 0));
    sim(3'b111, hb(2, 0));
    sim(3'b010, dn(2, 0));
    for (int k = 0; k < plan.size(); k++) begin
      drive(plan[k]);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL test_turn_left_straight step %0d: got %b required %b", k, observed(), e);
      end
    end
  endtask

  task automatic test_last_node();
    logic [9:0] e;
    plan.delete();
    rs();
    for (int i = 0; i < 8; i++) wr(3'(i), 3'b000, 10'd0);
    stp(3'b010, fol(0, 0));
    for (int i = 0; i < 8; i++) begin
      rep(3, 3'b111, fol(3'(i), 0));
      sim(3'b111, hb(3'(i), 0));
      sim(3'b010, man(3'b100, 3'(i), 0));
      rep(7, 3'b010, man(3'b100, 3'(i), 0));
      sim(3'b010, (i == 7) ? dn(3'd7, 0) : fol(3'(i + 1), 0));
    end
    sim(3'b010, dn(3'd7, 0));
    for (int k = 0; k < plan.size(); k++) begin
      drive(plan[k]);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL test_last_node step %0d: got %b required %b", k, observed(), e);
      end
    end
  endtask

  task automatic test_reset_mid_mag();
    logic [9:0] e;
    plan.delete();
    rs();
    wr(3'd0, 3'b100, 10'd0);
    stp(3'b010, fol(0, 0));
    rep(3, 3'b111, fol(0, 0));
    sim(3'b111, hb(0, 0));
    sim(3'b010, hb(0, 1));
    rep(5, 3'b010, hb(0, 1));
    rs();                                                  // mid-MAG
    add(1'b1, 1'b0, 1'b1, 3'd0, 3'b100, 3'b010, fol(0, 0)); // write dropped
    rep(3, 3'b111, fol(0, 0));
    sim(3'b111, hb(0, 0));
    sim(3'b010, dn(0, 0));                                 // entry 0 is 011 again
    for (int k = 0; k < plan.size(); k++) begin
      drive(plan[k]);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL test_reset_mid_mag step %0d: got %b required %b", k, observed(), e);
      end
    end
  endtask

  initial begin
    bus.start         = 1'b0;
    bus.adc_data      = 3'b010;
    bus.route_wr_en   = 1'b0;
    bus.route_wr_addr = 3'd0;
    bus.route_wr_data = 3'd0;
    @(negedge clk);
    test_reset();
    test_pick_turn();
    test_release();
    test_drop_end();
    test_debounce();
    test_lost();
    test_turn_left_straight();
    test_last_node();
    test_reset_mid_mag();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
